// File: rtl/relu_quant.sv
// Two-stage ReLU + round-half-up requantization pipeline over a COLS x COLS tile,
// with a valid/ready handshake and saturation / tile counters.
module relu_quant #(
    parameter int COLS  = 5,
    parameter int AB_BW = 25,
    parameter int Q_BW  = 8,
    parameter int SH_BW = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [SH_BW-1:0]          i_shift,
    input  logic [AB_BW*COLS*COLS-1:0] i_acc_bias,
    input  logic                      i_ready,
    output logic                      o_valid,
    output logic [Q_BW*COLS*COLS-1:0] o_act,
    output logic [15:0]               o_sat_cnt,
    output logic [15:0]               o_tile_cnt
);
    localparam int N  = COLS * COLS;
    localparam int XW = AB_BW + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [XW-1:0] Q_MAX = XW'((1 << Q_BW) - 1);

    logic                   s1_valid_q, s1_valid_d;
    logic [N-1:0][XW-1:0]   s1_data_q, s1_data_d;
    logic [SH_BW-1:0]       s1_shift_q, s1_shift_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [Q_BW*N-1:0]      s2_act_q, s2_act_d;
    logic [CW-1:0]          s2_sat_q, s2_sat_d;
    logic [15:0]            sat_cnt_q, sat_cnt_d;
    logic [15:0]            tile_cnt_q, tile_cnt_d;

    logic                   advance;
    logic                   out_hs;
    logic [N-1:0][XW-1:0]   relu_val;
    logic [N-1:0][XW-1:0]   rnd_sum;
    logic [N-1:0][XW-1:0]   shifted;
    logic [XW-1:0]          rnd;
    logic [Q_BW*N-1:0]      q_act;
    logic [CW-1:0]          q_sat;
    logic [16:0]            sat_sum;

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            relu_val[k] = i_acc_bias[k*AB_BW + AB_BW - 1] ? '0
                        : XW'(i_acc_bias[k*AB_BW +: AB_BW]);
        end
    end

    // Operands are non-negative after ReLU, so a logical shift equals the arithmetic one.
    always_comb begin
        rnd   = (s1_shift_q == '0) ? '0 : (XW'(1) << (s1_shift_q - SH_BW'(1)));
        q_act = '0;
        q_sat = '0;
        for (int unsigned k = 0; k < N; k++) begin
            rnd_sum[k] = s1_data_q[k] + rnd;
            shifted[k] = rnd_sum[k] >> s1_shift_q;
            if (int'(s1_shift_q) >= AB_BW) begin
                q_act[k*Q_BW +: Q_BW] = '0;
            end else if (shifted[k] > Q_MAX) begin
                q_act[k*Q_BW +: Q_BW] = '1;
                q_sat = q_sat + CW'(1);
            end else begin
                q_act[k*Q_BW +: Q_BW] = shifted[k][Q_BW-1:0];
            end
        end
    end

    always_comb begin
        advance    = en & (~s2_valid_q | i_ready);
        out_hs     = s2_valid_q & i_ready & en;
        o_ready    = advance & ~rst;

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_shift_d = s1_shift_q;
        s2_valid_d = s2_valid_q;
        s2_act_d   = s2_act_q;
        s2_sat_d   = s2_sat_q;
        sat_cnt_d  = sat_cnt_q;
        tile_cnt_d = tile_cnt_q;
        sat_sum    = {1'b0, sat_cnt_q} + 17'(s2_sat_q);

        if (advance) begin
            s1_valid_d = i_valid;
            s1_data_d  = relu_val;
            s1_shift_d = i_shift;
            s2_valid_d = s1_valid_q;
            s2_act_d   = q_act;
            s2_sat_d   = q_sat;
        end
        if (out_hs) begin
            sat_cnt_d  = sat_sum[16] ? '1 : sat_sum[15:0];
            tile_cnt_d = tile_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_shift_q <= '0;
            s2_valid_q <= 1'b0;
            s2_act_q   <= '0;
            s2_sat_q   <= '0;
            sat_cnt_q  <= '0;
            tile_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_shift_q <= s1_shift_d;
            s2_valid_q <= s2_valid_d;
            s2_act_q   <= s2_act_d;
            s2_sat_q   <= s2_sat_d;
            sat_cnt_q  <= sat_cnt_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    assign o_valid    = s2_valid_q;
    assign o_act      = s2_act_q;
    assign o_sat_cnt  = sat_cnt_q;
    assign o_tile_cnt = tile_cnt_q;
endmodule

// File: tb/tb_relu_quant.sv
// Bench for relu_quant: a tile-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_relu_quant;
    localparam int COLS  = 5;
    localparam int AB_BW = 25;
    localparam int Q_BW  = 8;
    localparam int SH_BW = 5;
    localparam int N     = COLS * COLS;

    logic                  clk = 1'b0;
    logic                  rst, en, i_valid, i_ready, o_ready, o_valid;
    logic [SH_BW-1:0]      i_shift;
    logic [AB_BW*N-1:0]    i_acc_bias;
    logic [Q_BW*N-1:0]     o_act;
    logic [15:0]           o_sat_cnt, o_tile_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    relu_quant #(.COLS(COLS), .AB_BW(AB_BW), .Q_BW(Q_BW), .SH_BW(SH_BW)) dut (
        .clk(clk), .rst(rst), .en(en), .i_valid(i_valid), .o_ready(o_ready),
        .i_shift(i_shift), .i_acc_bias(i_acc_bias), .i_ready(i_ready),
        .o_valid(o_valid), .o_act(o_act), .o_sat_cnt(o_sat_cnt), .o_tile_cnt(o_tile_cnt)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Expected activations straight from the arithmetic rules.
    function automatic logic [Q_BW*N-1:0] exp_act(input logic [AB_BW*N-1:0] b,
                                                  input logic [SH_BW-1:0] sh,
                                                  output int nsat);
        logic signed [AB_BW-1:0] e;
        longint x, q;
        exp_act = '0;
        nsat = 0;
        for (int k = 0; k < N; k++) begin
            e = b[k*AB_BW +: AB_BW];
            x = longint'(e);
            if (x < 0) x = 0;
            if (int'(sh) >= AB_BW) q = 0;
            else if (sh == 0) q = x;
            else q = (x + (longint'(1) << (sh - 1))) >> sh;
            if (q > (1 << Q_BW) - 1) begin
                q = (1 << Q_BW) - 1;
                nsat++;
            end
            exp_act[k*Q_BW +: Q_BW] = Q_BW'(q);
        end
    endfunction

    function automatic logic [AB_BW*N-1:0] mk_tile(input int seed);
        mk_tile = '0;
        for (int k = 0; k < N; k++)
            mk_tile[k*AB_BW +: AB_BW] = AB_BW'(k * 37 + seed * 300 - 150);
    endfunction

    // Tile-level model: two-deep delay line of expected tiles plus counters.
    logic              m_v1 = 1'b0, m_v2 = 1'b0;
    logic [Q_BW*N-1:0] m_a1 = '0, m_a2 = '0;
    int                m_s1 = 0, m_s2 = 0, m_sat = 0, ns;
    logic [15:0]       m_tile = '0;
    logic              exp_ready, adv;

    always @(negedge clk) begin
        exp_ready = en && !rst && (!m_v2 || i_ready);
        check("o_ready", 256'(o_ready), 256'(exp_ready));
        check("o_valid", 256'(o_valid), 256'(m_v2));
        if (m_v2) check("o_act", 256'(o_act), 256'(m_a2));
        check("o_sat_cnt", 256'(o_sat_cnt), 256'(m_sat));
        check("o_tile_cnt", 256'(o_tile_cnt), 256'(m_tile));
        adv = en && (!m_v2 || i_ready);
        if (rst) begin
            m_v1 = 0; m_v2 = 0; m_a1 = '0; m_a2 = '0;
            m_s1 = 0; m_s2 = 0; m_sat = 0; m_tile = '0;
        end else if (adv) begin
            if (m_v2 && i_ready) begin
                m_tile = m_tile + 16'd1;
                m_sat  = (m_sat + m_s2 > 65535) ? 65535 : m_sat + m_s2;
            end
            m_v2 = m_v1; m_a2 = m_a1; m_s2 = m_s1;
            m_v1 = i_valid;
            m_a1 = exp_act(i_acc_bias, i_shift, ns);
            m_s1 = ns;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [AB_BW*N-1:0] t35;
    logic [Q_BW*N-1:0]  r35, snap_act, all100;
    logic [15:0]        snap_tile, snap_sat;
    int                 pin_sat;
    int                 v35[5] = '{-5, 23, 24, 4095, 4096};
    int                 q35[5] = '{0, 1, 2, 255, 255};

    initial begin
        rst = 1'b1; en = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_shift = '0; i_acc_bias = '0;
        tick(); tick();
        check("rst_o_ready", 256'(o_ready), 256'(0));
        check("rst_o_valid", 256'(o_valid), 256'(0));
        check("rst_o_act", 256'(o_act), 256'(0));
        check("rst_tile_cnt", 256'(o_tile_cnt), 256'(0));
        rst = 1'b0;

        // Pin the model against hand-computed values.
        t35 = '0; r35 = '0;
        for (int k = 0; k < 5; k++) begin
            t35[k*AB_BW +: AB_BW] = AB_BW'(v35[k]);
            r35[k*Q_BW +: Q_BW]   = Q_BW'(q35[k]);
        end
        check("pin_model_sh4", 256'(exp_act(t35, 5'd4, pin_sat)), 256'(r35));
        check("pin_model_sat", 256'(pin_sat), 256'(2));
        check("pin_model_shbig", 256'(exp_act(t35, 5'd25, pin_sat)), 256'(0));

        // Plain pass-through at shift 0, latency 2.
        all100 = '0;
        for (int k = 0; k < N; k++) begin
            i_acc_bias[k*AB_BW +: AB_BW] = AB_BW'(100);
            all100[k*Q_BW +: Q_BW] = 8'd100;
        end
        i_shift = '0; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("lat_cycle1_valid", 256'(o_valid), 256'(0));
        tick();
        check("lat_cycle2_valid", 256'(o_valid), 256'(1));
        check("act_100", 256'(o_act), 256'(all100));
        tick();
        check("tile_cnt_1", 256'(o_tile_cnt), 256'(1));
        check("sat_cnt_0", 256'(o_sat_cnt), 256'(0));

        // Rounding and saturation.
        i_acc_bias = t35; i_shift = 5'd4; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        check("act_round_sat", 256'(o_act), 256'(r35));
        tick();
        check("sat_cnt_2", 256'(o_sat_cnt), 256'(2));
        check("tile_cnt_2", 256'(o_tile_cnt), 256'(2));

        // Back-to-back tiles with a 4-cycle downstream stall.
        i_acc_bias = mk_tile(1); i_shift = 5'd3; i_valid = 1'b1;
        tick();
        i_acc_bias = mk_tile(2); i_shift = 5'd0;
        tick();
        i_acc_bias = mk_tile(3); i_shift = 5'd27; i_ready = 1'b0;
        snap_act = o_act;
        check("stall_o_valid", 256'(o_valid), 256'(1));
        for (int c = 0; c < 4; c++) begin
            #2;
            check("stall_o_ready", 256'(o_ready), 256'(0));
            tick();
            check("stall_act_hold", 256'(o_act), 256'(snap_act));
        end
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick(); tick(); tick();
        check("tile_cnt_after_stall", 256'(o_tile_cnt), 256'(5));

        // Enable dropped for 3 cycles mid-stream.
        i_acc_bias = mk_tile(4); i_shift = 5'd2; i_valid = 1'b1;
        tick();
        i_acc_bias = mk_tile(5); i_shift = 5'd24;
        tick();
        i_acc_bias = mk_tile(6); i_shift = 5'd1; en = 1'b0;
        snap_act = o_act; snap_tile = o_tile_cnt; snap_sat = o_sat_cnt;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("en0_o_ready", 256'(o_ready), 256'(0));
            tick();
            check("en0_o_valid", 256'(o_valid), 256'(1));
            check("en0_act_hold", 256'(o_act), 256'(snap_act));
            check("en0_tile_hold", 256'(o_tile_cnt), 256'(snap_tile));
            check("en0_sat_hold", 256'(o_sat_cnt), 256'(snap_sat));
        end
        en = 1'b1;
        tick();
        i_acc_bias = mk_tile(7); i_shift = 5'd5;
        tick();
        i_valid = 1'b0;
        tick(); tick(); tick();
        check("tile_cnt_after_en", 256'(o_tile_cnt), 256'(9));

        // Reset with two tiles in flight and downstream ready.
        i_acc_bias = mk_tile(8); i_shift = 5'd0; i_valid = 1'b1;
        tick();
        i_acc_bias = mk_tile(9);
        tick();
        i_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_o_valid", 256'(o_valid), 256'(0));
        check("midrst_tile_cnt", 256'(o_tile_cnt), 256'(0));
        check("midrst_sat_cnt", 256'(o_sat_cnt), 256'(0));
        for (int c = 0; c < 4; c++) begin
            tick();
            check("postrst_no_delivery", 256'(o_tile_cnt), 256'(0));
        end

        // Fully saturated stream: sat counter clamp and tile counter wrap.
        for (int k = 0; k < N; k++) i_acc_bias[k*AB_BW +: AB_BW] = 25'h0FF_FFFF;
        i_shift = '0; i_valid = 1'b1;
        for (int i = 1; i <= 65536; i++) begin
            tick();
            if (i == 2623) begin
                check("sat_cnt_65525", 256'(o_sat_cnt), 256'(65525));
                check("tile_cnt_2621", 256'(o_tile_cnt), 256'(2621));
            end
            if (i == 2624) check("sat_cnt_clamp", 256'(o_sat_cnt), 256'(16'hFFFF));
        end
        i_valid = 1'b0;
        tick(); tick();
        check("tile_cnt_wrap", 256'(o_tile_cnt), 256'(0));
        check("sat_cnt_held", 256'(o_sat_cnt), 256'(16'hFFFF));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/relu_quant.md
RELU_QUANT -- requirements
Module: relu_quant

Interface
REQ-001 SHALL have parameter COLS, default 5, meaning tile edge; the tile holds COLS*COLS elements.
REQ-002 SHALL have parameter AB_BW, default 25, meaning signed width of each biased-accumulator input element.
REQ-003 SHALL have parameter Q_BW, default 8, meaning unsigned width of each output activation.
REQ-004 SHALL have parameter SH_BW, default 5, meaning width of the requantization shift amount.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: global enable; 0 freezes the block.
REQ-008 SHALL have port i_valid, input, 1 bit: upstream tile valid.
REQ-009 SHALL have port o_ready, output, 1 bit: block accepts a tile this cycle.
REQ-010 SHALL have port i_shift, input, SH_BW bits: right-shift amount, sampled with the tile.
REQ-011 SHALL have port i_acc_bias, input, AB_BW*COLS*COLS bits: signed elements; element k occupies bits [(k+1)*AB_BW-1 -: AB_BW].
REQ-012 SHALL have port i_ready, input, 1 bit: downstream accepts output.
REQ-013 SHALL have port o_valid, output, 1 bit: output tile valid.
REQ-014 SHALL have port o_act, output, Q_BW*COLS*COLS bits: unsigned activations, same element packing as the input.
REQ-015 SHALL have port o_sat_cnt, output, 16 bits: count of saturated elements delivered.
REQ-016 SHALL have port o_tile_cnt, output, 16 bits: count of tiles delivered.

Function
REQ-017 SHALL implement a 2-stage pipeline, S1 and S2, each holding a valid bit, data and per-tile shift.
REQ-018 SHALL define advance = en & (~o_valid | i_ready); o_ready = advance; input handshake = i_valid & o_ready; output handshake = o_valid & i_ready & en.
REQ-019 SHALL, on advance, load S1 from the input (valid = i_valid) and load S2 from S1; with advance low both stages hold.
REQ-020 SHALL in S1 apply ReLU per element: negative -> 0, otherwise unchanged; held in AB_BW+1 bits.
REQ-021 SHALL in S2 compute per element (x + R) >>> sh, with R = 0 when sh = 0, otherwise R = 1 << (sh-1) (round half up); intermediate width AB_BW+1, no overflow.
REQ-022 SHALL in S2 saturate to Q_BW bits unsigned: value > 2^Q_BW-1 -> 2^Q_BW-1; each element flagged saturated when clamped.
REQ-023 SHALL produce 0 for any element when sh >= AB_BW.
REQ-024 SHALL drive o_valid = S2 valid and o_act = S2 data; latency is 2 cycles from input handshake to o_valid with i_ready held high.
REQ-025 SHALL hold o_act and o_valid stable while o_valid=1 and i_ready=0.
REQ-026 SHALL sustain one tile per cycle with i_valid=i_ready=en=1.
REQ-027 SHALL on each output handshake add the tile's saturated-element count (0..COLS*COLS) to o_sat_cnt, clamping at 16'hFFFF.
REQ-028 SHALL on each output handshake increment o_tile_cnt by 1, wrapping 16'hFFFF -> 0.
REQ-029 SHALL with en=0 force o_ready=0, freeze all registers and counters, and keep o_valid/o_act unchanged.
REQ-030 SHALL sample i_shift per tile in S1 so that shift changes do not affect tiles already in flight.

Reset
REQ-031 SHALL on rst=1 at a clock edge clear both valid bits, S1/S2 data, o_sat_cnt and o_tile_cnt to 0 (o_valid=0, o_act=0), regardless of en, overriding any handshake.
REQ-032 SHALL in the cycle rst is asserted drive o_ready low; it follows REQ-018 from the first cycle after rst deasserts.
REQ-033 SHALL discard in-flight tiles when rst is asserted mid-operation; no output handshake for them occurs.

Verification
REQ-034 SHALL pass: sh=0, all elements = 100, one valid cycle, i_ready=1 -> o_valid high exactly 2 cycles later, all o_act=100, o_sat_cnt=0, o_tile_cnt=1.
REQ-035 SHALL pass: sh=4, elements {-5, 23, 24, 4095, 4096}, rest 0 -> outputs {0, 1, 2, 255, 255}, o_sat_cnt += 2.
REQ-036 SHALL pass: 3 back-to-back tiles, i_ready=0 for 4 cycles after the first o_valid -> o_act held stable, o_ready=0 while stalled, all 3 tiles delivered in order, o_tile_cnt=3.
REQ-037 SHALL pass: en=0 for 3 cycles mid-stream -> no register change, o_ready=0, stream resumes unchanged.
REQ-038 SHALL pass: rst pulse with 2 tiles in flight -> next cycle o_valid=0, counters 0, no delivery of those tiles.
REQ-039 SHALL pass: o_sat_cnt preloaded near 16'hFFFF by 2621 tiles each fully saturated (25 each) -> count clamps at 16'hFFFF; o_tile_cnt wraps after 65536 tiles.
